// File: rtl/fp_hysteresis_detector.sv
// fp_hysteresis_detector: fixed-point analog to digital level converter
// with threshold hysteresis and consecutive-sample debounce.
module fp_hysteresis_detector #(
  parameter int WIDTH     = 34,
  parameter int FRAC      = 13,
  parameter int THRESH_HI = 4096,
  parameter int THRESH_LO = -4096,
  parameter int DEBOUNCE  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_analog,
  output logic                    out_digital,
  output logic                    out_rise,
  output logic                    out_fall,
  output logic                    out_pending
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  localparam logic signed [WIDTH-1:0] TH_HI = WIDTH'(THRESH_HI);
  localparam logic signed [WIDTH-1:0] TH_LO = WIDTH'(THRESH_LO);
  localparam logic [CW:0]             DB    = (CW + 1)'(DEBOUNCE);

  if (DEBOUNCE < 1 || DEBOUNCE > 255 || THRESH_LO > THRESH_HI ||
      FRAC < 0 || FRAC >= WIDTH) begin : g_bad_params
    $error("fp_hysteresis_detector: illegal parameters");
  end

  typedef enum logic [1:0] {
    LOW,
    RISE_PEND,
    HIGH,
    FALL_PEND
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          rise_d, fall_d;
  logic          q_hi, q_lo;
  logic          run_done;
  logic [CW:0]   cnt_inc;

  assign q_hi     = in_analog >= TH_HI;
  assign q_lo     = in_analog <= TH_LO;
  assign cnt_inc  = {1'b0, cnt} + (CW + 1)'(1);
  assign run_done = cnt_inc == DB;

  // Next state, run counter and edge pulses for a valid sample
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (in_valid) begin
      unique case (state)
        LOW: begin
          cnt_d = '0;
          if (q_hi) begin
            if (DEBOUNCE == 1) begin
              state_d = HIGH;
              rise_d  = 1'b1;
            end else begin
              state_d = RISE_PEND;
              cnt_d   = CW'(1);
            end
          end
        end
        RISE_PEND: begin
          if (!q_hi) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (run_done) begin
            state_d = HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        HIGH: begin
          cnt_d = '0;
          if (q_lo) begin
            if (DEBOUNCE == 1) begin
              state_d = LOW;
              fall_d  = 1'b1;
            end else begin
              state_d = FALL_PEND;
              cnt_d   = CW'(1);
            end
          end
        end
        FALL_PEND: begin
          if (!q_lo) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (run_done) begin
            state_d = LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOW;
      cnt         <= '0;
      out_digital <= 1'b0;
      out_rise    <= 1'b0;
      out_fall    <= 1'b0;
      out_pending <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      out_digital <= (state_d == HIGH) || (state_d == FALL_PEND);
      out_pending <= (state_d == RISE_PEND) || (state_d == FALL_PEND);
      out_rise    <= rise_d;
      out_fall    <= fall_d;
    end
  end

endmodule
